// File: rtl/alu_pipe_nbit.sv
// alu_pipe_nbit: 2-stage valid/ready pipelined ALU (8 ops + flags); define ALU_PIPE_SAT_EN for saturating signed ADD/SUB
module alu_pipe_nbit #(
    parameter int WIDTH = 8,
    parameter int SHW   = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             zero,
    output logic             neg,
    output logic             ovf
);
    logic             s1_valid_q, s2_valid_q;
    logic [WIDTH-1:0] a_q, b_q, res_q;
    logic [2:0]       op_q;
    logic             carry_q, zero_q, neg_q, ovf_q;
    logic             adv1, adv2, sub, aovf, carry_d, ovf_d;
    logic [WIDTH-1:0] bb, arith, res_d;
    logic [WIDTH:0]   sum, shl, shr;
    assign adv2     = !s2_valid_q | out_ready;
    assign adv1     = !s1_valid_q | adv2;
    assign in_ready = adv1;
    assign sub  = op_q == 3'd1;
    assign bb   = sub ? ~b_q : b_q;
    assign sum  = {1'b0, a_q} + {1'b0, bb} + {{WIDTH{1'b0}}, sub};
    assign aovf = (a_q[WIDTH-1] == bb[WIDTH-1]) & (sum[WIDTH-1] != a_q[WIDTH-1]);
    assign shl  = {1'b0, a_q} << b_q[SHW-1:0];
    assign shr  = {a_q, 1'b0} >> b_q[SHW-1:0];
`ifdef ALU_PIPE_SAT_EN
    assign arith = aovf ? {a_q[WIDTH-1], {(WIDTH-1){!a_q[WIDTH-1]}}} : sum[WIDTH-1:0];
`else
    assign arith = sum[WIDTH-1:0];
`endif
    always_comb begin
        res_d   = '0;
        carry_d = 1'b0;
        ovf_d   = 1'b0;
        case (op_q)
            3'd0, 3'd1: begin
                res_d   = arith;
                carry_d = sum[WIDTH];
                ovf_d   = aovf;
            end
            3'd2: res_d = a_q & b_q;
            3'd3: res_d = a_q | b_q;
            3'd4: res_d = a_q ^ b_q;
            3'd5: begin
                res_d   = shl[WIDTH-1:0];
                carry_d = shl[WIDTH];
            end
            3'd6: begin
                res_d   = shr[WIDTH:1];
                carry_d = shr[0];
            end
            default: res_d = {{(WIDTH-1){1'b0}}, $signed(a_q) < $signed(b_q)};
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            op_q       <= '0;
            res_q      <= '0;
            carry_q    <= 1'b0;
            zero_q     <= 1'b0;
            neg_q      <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            if (adv1) begin
                s1_valid_q <= in_valid;
                if (in_valid) begin
                    a_q  <= a;
                    b_q  <= b;
                    op_q <= op;
                end
            end
            if (adv2) begin
                s2_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    res_q   <= res_d;
                    carry_q <= carry_d;
                    zero_q  <= res_d == '0;
                    neg_q   <= res_d[WIDTH-1];
                    ovf_q   <= ovf_d;
                end
            end
        end
    end
    assign out_valid = s2_valid_q;
    assign result    = res_q;
    assign carry     = carry_q;
    assign zero      = zero_q;
    assign neg       = neg_q;
    assign ovf       = ovf_q;
endmodule

// File: tb/tb_alu_pipe_nbit.sv
// tb_alu_pipe_nbit: directed + random scoreboard bench for alu_pipe_nbit at WIDTH=8
module tb_alu_pipe_nbit;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] a = '0;
    logic [7:0] b = '0;
    logic [2:0] op = '0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [7:0] result;
    logic       carry, zero, neg, ovf;
    int         checks = 0;
    int         failures = 0;
    int         accepts = 0;
    int         emerged = 0;
    logic [11:0] sb[$];
    alu_pipe_nbit #(.WIDTH(8), .SHW(3)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .carry(carry), .zero(zero), .neg(neg), .ovf(ovf)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask
    function automatic logic [11:0] model(input logic [7:0] x, input logic [7:0] y, input logic [2:0] o);
        logic [8:0] s;
        logic [7:0] r;
        logic       c, v;
        int         sh;
        sh = int'(y[2:0]);
        r = '0;
        c = 1'b0;
        v = 1'b0;
        case (o)
            3'd0: begin
                s = {1'b0, x} + {1'b0, y};
                r = s[7:0];
                c = s[8];
                v = (x[7] == y[7]) && (r[7] != x[7]);
            end
            3'd1: begin
                s = {1'b0, x} - {1'b0, y};
                r = s[7:0];
                c = x >= y;
                v = (x[7] != y[7]) && (r[7] != x[7]);
            end
            3'd2: r = x & y;
            3'd3: r = x | y;
            3'd4: r = x ^ y;
            3'd5: begin
                r = x << sh;
                c = (sh == 0) ? 1'b0 : x[8-sh];
            end
            3'd6: begin
                r = x >> sh;
                c = (sh == 0) ? 1'b0 : x[sh-1];
            end
            default: r = ($signed(x) < $signed(y)) ? 8'd1 : 8'd0;
        endcase
`ifdef ALU_PIPE_SAT_EN
        if (v) r = x[7] ? 8'h80 : 8'h7F;
`endif
        return {r, c, r == 8'h00, r[7], v};
    endfunction
    task automatic xfer(input logic [7:0] x, input logic [7:0] y, input logic [2:0] o, input logic [11:0] e);
        int n;
        a = x;
        b = y;
        op = o;
        in_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk("accept_timeout", {15'd0, in_ready}, 16'd1);
        else begin
            sb.push_back(e);
            accepts++;
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask
    always @(negedge clk) begin
        if (rst) sb.delete();
        else if (out_valid && out_ready) begin
            emerged++;
            if (sb.size() == 0) chk("unexpected_output", {4'd0, result, carry, zero, neg, ovf}, 16'hFFFF);
            else chk("result_flags", {4'd0, result, carry, zero, neg, ovf}, {4'd0, sb.pop_front()});
        end
    end
    initial begin
        int n;
        int e0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("reset_out_valid", {15'd0, out_valid}, 16'd0);
        chk("reset_result_flags", {4'd0, result, carry, zero, neg, ovf}, 16'd0);
        chk("reset_in_ready", {15'd0, in_ready}, 16'd1);
`ifdef ALU_PIPE_SAT_EN
        xfer(8'h7F, 8'h01, 3'd0, {8'h7F, 1'b0, 1'b0, 1'b0, 1'b1});
`else
        xfer(8'h7F, 8'h01, 3'd0, {8'h80, 1'b0, 1'b0, 1'b1, 1'b1});
`endif
        chk("latency_cycle1", {15'd0, out_valid}, 16'd0);
        @(posedge clk);
        #1 chk("latency_cycle2", {15'd0, out_valid}, 16'd1);
        xfer(8'h08, 8'h02, 3'd1, {8'h06, 1'b1, 1'b0, 1'b0, 1'b0});
        xfer(8'h02, 8'h08, 3'd1, {8'hFA, 1'b0, 1'b0, 1'b1, 1'b0});
        xfer(8'h81, 8'h01, 3'd5, {8'h02, 1'b1, 1'b0, 1'b0, 1'b0});
        xfer(8'h81, 8'h01, 3'd6, {8'h40, 1'b1, 1'b0, 1'b0, 1'b0});
        xfer(8'h81, 8'h00, 3'd5, {8'h81, 1'b0, 1'b0, 1'b1, 1'b0});
        xfer(8'h81, 8'h00, 3'd6, {8'h81, 1'b0, 1'b0, 1'b1, 1'b0});
        xfer(8'h80, 8'h01, 3'd1, model(8'h80, 8'h01, 3'd1));
        xfer(8'h55, 8'h55, 3'd4, model(8'h55, 8'h55, 3'd4));
        fork
            for (int i = 0; i < 30; i++) begin
                logic [7:0] x, y;
                logic [2:0] o;
                x = 8'($urandom);
                y = 8'($urandom);
                o = 3'($urandom);
                xfer(x, y, o, model(x, y, o));
            end
            begin
                repeat (60) begin
                    @(posedge clk);
                    #1 out_ready = 1'($urandom);
                end
                out_ready = 1'b1;
            end
        join
        out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1 out_ready = 1'b0;
        e0 = accepts;
        fork
            begin
                xfer(8'h10, 8'h20, 3'd0, model(8'h10, 8'h20, 3'd0));
                xfer(8'hF0, 8'h3C, 3'd2, model(8'hF0, 8'h3C, 3'd2));
                xfer(8'hF0, 8'h0F, 3'd3, model(8'hF0, 8'h0F, 3'd3));
                xfer(8'h05, 8'h09, 3'd7, model(8'h05, 8'h09, 3'd7));
            end
            begin
                repeat (5) @(posedge clk);
                #1 chk("stall_in_ready", {15'd0, in_ready}, 16'd0);
                chk("stall_accepts", 16'(accepts - e0), 16'd2);
                chk("stall_out_valid", {15'd0, out_valid}, 16'd1);
                chk("stall_hold_result", {8'd0, result}, 16'h0030);
                out_ready = 1'b1;
            end
        join
        n = 0;
        while (sb.size() != 0 && n < 20) begin
            @(posedge clk);
            n++;
        end
        #1 chk("drain_empty", 16'(sb.size()), 16'd0);
        out_ready = 1'b0;
        xfer(8'h11, 8'h22, 3'd0, model(8'h11, 8'h22, 3'd0));
        xfer(8'h33, 8'h44, 3'd1, model(8'h33, 8'h44, 3'd1));
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        chk("midreset_out_valid", {15'd0, out_valid}, 16'd0);
        chk("midreset_in_ready", {15'd0, in_ready}, 16'd1);
        e0 = emerged;
        out_ready = 1'b1;
        repeat (6) @(posedge clk);
        #1 chk("midreset_nothing_emerges", 16'(emerged - e0), 16'd0);
        xfer(8'hFF, 8'h01, 3'd7, {8'h01, 1'b0, 1'b0, 1'b0, 1'b0});
        xfer(8'h01, 8'hFF, 3'd7, {8'h00, 1'b0, 1'b1, 1'b0, 1'b0});
        n = 0;
        while (sb.size() != 0 && n < 20) begin
            @(posedge clk);
            n++;
        end
        #1 chk("final_drain_empty", 16'(sb.size()), 16'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
